// File: rtl/operand_queue.sv
// operand_queue: in-order FIFO that replays result words as ALU operands over valid/ready.
// Define OPQ_ALMOST_FULL_EN to add the almost_full output.
module operand_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
`ifdef OPQ_ALMOST_FULL_EN
  output logic              almost_full,
`endif
  output logic              drop_err
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push = wr_valid && !full;
  assign pop = rd_ready && !empty;
  // Zero while empty so the reset value of rd_data is defined without resetting storage.
  assign rd_data = empty ? '0 : mem[rd_ptr];
`ifdef OPQ_ALMOST_FULL_EN
  assign almost_full = count >= (ADDR_W+1)'(DEPTH-1);
`endif
  always_ff @(posedge clk)
    if (push && !clr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
      count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_err <= 1'b0;
    else if (wr_valid && full) drop_err <= 1'b1;
endmodule

// File: tb/tb_operand_queue.sv
// tb_operand_queue: randomized and directed checks of operand_queue against a queue-based model.
module tb_operand_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n, clr, wr_valid, rd_ready;
  logic [15:0] wr_data, rd_data;
  logic wr_ready, rd_valid, full, empty, drop_err;
  logic [2:0] count;
`ifdef OPQ_ALMOST_FULL_EN
  logic almost_full;
`endif
  int vectors = 0, miscompares = 0;
  logic [15:0] q[$];
  bit drop_m = 1'b0;

  operand_queue dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty),
`ifdef OPQ_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: an unbounded queue capped at DEPTH; clr wins over push and pop.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      drop_m <= 1'b0;
    end else begin
      if (wr_valid && q.size() == DEPTH) drop_m <= 1'b1;
      if (clr) q.delete();
      else begin
        automatic bit do_push = wr_valid && q.size() < DEPTH;
        automatic bit do_pop = rd_ready && q.size() > 0;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(wr_data);
      end
    end

  always @(negedge clk) begin
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
    check("drop_err", 32'(drop_err), 32'(drop_m));
    if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
`ifdef OPQ_ALMOST_FULL_EN
    check("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 1));
`endif
  end

  task automatic step(input logic wv, input logic [15:0] wd, input logic rr, input logic c);
    wr_valid = wv;
    wr_data = wd;
    rd_ready = rr;
    clr = c;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] words [4];
    words = '{16'h1234, 16'hABCD, 16'h00FF, 16'hFFFF};
    rst_n = 1'b0;
    clr = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    // Fill with four words, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(rd_data), 32'(words[i]));
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    // Overflow attempt is dropped and flagged.
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("ovf_drop_err", 32'(drop_err), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_data", 32'(rd_data), 32'(words[i]));
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("ovf_empty", 32'(empty), 32'd1);
    // Push into empty with rd_ready high: no pop on that edge.
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    check("fwft_valid", 32'(rd_valid), 32'd1);
    check("fwft_data", 32'(rd_data), 32'h5A5A);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("fwft_popped", 32'(empty), 32'd1);
    // Steady state at count=2 across pointer wrap.
    step(1'b1, 16'hA000, 1'b0, 1'b0);
    step(1'b1, 16'hA001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("wrap_data", 32'(rd_data), 32'(16'hA000 + 16'(i)));
      step(1'b1, 16'hA002 + 16'(i), 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'd2);
    end
    // clr with simultaneous push at count=3.
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    check("pre_clr_count", 32'(count), 32'd3);
`ifdef OPQ_ALMOST_FULL_EN
    check("pre_clr_af", 32'(almost_full), 32'd1);
`endif
    step(1'b1, 16'h8888, 1'b0, 1'b1);
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_keeps_drop", 32'(drop_err), 32'd1);
`ifdef OPQ_ALMOST_FULL_EN
    check("clr_af", 32'(almost_full), 32'd0);
`endif
    // Async reset mid-traffic at count=3.
    for (int i = 0; i < 3; i++) step(1'b1, words[i], 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    check("arst_drop_err", 32'(drop_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Random traffic with phases biased towards filling and draining.
    for (int i = 0; i < 3000; i++) begin
      automatic int phase = (i / 200) % 3;
      step(($urandom_range(0, 3) < (phase == 0 ? 3 : phase == 1 ? 1 : 2)),
           16'($urandom()),
           ($urandom_range(0, 3) < (phase == 0 ? 1 : phase == 1 ? 3 : 2)),
           ($urandom_range(0, 63) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
